// File: rtl/iob_pbus_cmd_master_pkg.sv
// Shared types and defaults for the pbus command master.
// State encodings, parameter defaults, timeout error data.
package iob_pbus_cmd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RSP    = 2'd3
  } state_t;

  localparam int ADDR_W_DEF          = 32;
  localparam int DATA_W_DEF          = 32;
  localparam int FIFO_DEPTH_LOG2_DEF = 2;
  localparam int TIMEOUT_W_DEF       = 16;

  localparam logic [63:0] TMO_RDATA = '1;

endpackage

// File: rtl/iob_pbus_cmd_master_if.sv
// Command, response and IOB signals of the pbus master.
// master = the block itself, slave = host/IOB side.
interface iob_pbus_cmd_master_if
  import iob_pbus_cmd_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic                cmd_we_i;
  logic [ADDR_W-1:0]   cmd_addr_i;
  logic [DATA_W-1:0]   cmd_wdata_i;
  logic [DATA_W/8-1:0] cmd_wstrb_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [DATA_W-1:0]   rsp_rdata_o;
  logic                rsp_err_o;
  logic                iob_valid_o;
  logic [ADDR_W-1:0]   iob_addr_o;
  logic [DATA_W-1:0]   iob_wdata_o;
  logic [DATA_W/8-1:0] iob_wstrb_o;
  logic                iob_ready_i;
  logic                iob_rvalid_i;
  logic [DATA_W-1:0]   iob_rdata_i;
  logic                busy_o;

  modport master (
    input  cmd_valid_i, cmd_we_i,
    input  cmd_addr_i, cmd_wdata_i,
    input  cmd_wstrb_i, rsp_ready_i,
    input  iob_ready_i, iob_rvalid_i,
    input  iob_rdata_i,
    output cmd_ready_o, rsp_valid_o,
    output rsp_rdata_o, rsp_err_o,
    output iob_valid_o, iob_addr_o,
    output iob_wdata_o, iob_wstrb_o,
    output busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i,
    output cmd_addr_i, cmd_wdata_i,
    output cmd_wstrb_i, rsp_ready_i,
    output iob_ready_i, iob_rvalid_i,
    output iob_rdata_i,
    input  cmd_ready_o, rsp_valid_o,
    input  rsp_rdata_o, rsp_err_o,
    input  iob_valid_o, iob_addr_o,
    input  iob_wdata_o, iob_wstrb_o,
    input  busy_o
  );
endinterface

// File: rtl/iob_pbus_cmd_master_fifo.sv
// Command FIFO: {we, addr, wdata, wstrb} entries.
// Push is refused when full, pop when empty.
module iob_pbus_cmd_fifo #(
  parameter int W  = 69,
  parameter int DL = 2
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  input  logic         cke_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [DL:0]  count_o
);
  localparam logic [DL:0] DEPTH = (DL+1)'(1 << DL);

  logic [W-1:0]  r_mem [1 << DL];
  logic [DL-1:0] r_wptr;
  logic [DL-1:0] r_rptr;
  logic [DL:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign full_o  = (r_cnt == DEPTH);
  assign empty_o = (r_cnt == '0);
  assign count_o = r_cnt;
  assign data_o  = r_mem[r_rptr];

  // pointers and occupancy; push+pop keeps count
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (cke_i) begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // entry storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (cke_i && w_push) r_mem[r_wptr] <= data_i;
  end
endmodule

// File: rtl/iob_pbus_cmd_master.sv
// pbus command master: FIFO -> single IOB txn -> response.
// Optional timeout: IOB_PBUS_CMD_MASTER_TIMEOUT_EN.
module iob_pbus_cmd_master
  import iob_pbus_cmd_master_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
  parameter int TIMEOUT_W       = TIMEOUT_W_DEF
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic cke_i,
  iob_pbus_cmd_master_if.master bus
);
  localparam int SW = DATA_W / 8;
  localparam int FW = 1 + ADDR_W + DATA_W + SW;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [SW-1:0]       r_wstrb;
  logic                r_iob_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic [FW-1:0]       w_fifo_d;
  logic [FW-1:0]       w_fifo_q;
  logic                w_full;
  logic                w_empty;
  logic [FIFO_DEPTH_LOG2:0] w_count;
  logic                w_pop;
  logic                w_fin;
  logic                w_zero;
  logic                w_cap;
  logic                w_tmo;
  logic                w_ack;
  logic                w_tmo_hit;

  assign w_fifo_d = {bus.cmd_we_i,
                     bus.cmd_addr_i,
                     bus.cmd_wdata_i,
                     bus.cmd_we_i ? bus.cmd_wstrb_i
                                  : SW'(0)};

  iob_pbus_cmd_fifo #(
    .W  (FW),
    .DL (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .push_i   (bus.cmd_valid_i),
    .pop_i    (w_pop),
    .data_i   (w_fifo_d),
    .data_o   (w_fifo_q),
    .full_o   (w_full),
    .empty_o  (w_empty),
    .count_o  (w_count)
  );

`ifdef IOB_PBUS_CMD_MASTER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tmo;
  logic                 r_err;

  assign w_tmo_hit = (r_tmo == '1);

  // timeout counter: clear on issue, count while waiting
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_tmo <= '0;
    end else if (cke_i) begin
      if (w_pop)
        r_tmo <= '0;
      else if (r_state == ST_REQ || r_state == ST_WAIT_R)
        r_tmo <= r_tmo + 1'b1;
    end
  end

  // error flag lives until the response is taken
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)   r_err <= 1'b0;
    else if (cke_i) begin
      if (w_tmo)      r_err <= 1'b1;
      else if (w_ack) r_err <= 1'b0;
    end
  end

  assign bus.rsp_err_o = r_err;
`else
  assign w_tmo_hit     = 1'b0;
  assign bus.rsp_err_o = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)   r_state <= ST_IDLE;
    else if (cke_i)  r_state <= w_state_nxt;
  end

  // next state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_pop  = 1'b0;
    w_fin  = 1'b0;
    w_zero = 1'b0;
    w_cap  = 1'b0;
    w_tmo  = 1'b0;
    w_ack  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.iob_ready_i) begin
          w_fin = 1'b1;
          if (r_we) begin
            w_zero      = 1'b1;
            w_state_nxt = ST_RSP;
          end else if (bus.iob_rvalid_i) begin
            w_cap       = 1'b1;
            w_state_nxt = ST_RSP;
          end else begin
            w_state_nxt = ST_WAIT_R;
          end
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RSP;
        end
      end
      ST_WAIT_R: begin
        if (bus.iob_rvalid_i) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_RSP;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready_i) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // request fields, IOB valid and response data
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_iob_valid <= 1'b0;
      r_rdata     <= '0;
    end else if (cke_i) begin
      if (w_pop) begin
        {r_we, r_addr, r_wdata, r_wstrb} <= w_fifo_q;
      end
      unique case (1'b1)
        w_pop:         r_iob_valid <= 1'b1;
        w_fin | w_tmo: r_iob_valid <= 1'b0;
        default:       r_iob_valid <= r_iob_valid;
      endcase
      unique case (1'b1)
        w_zero:  r_rdata <= '0;
        w_cap:   r_rdata <= bus.iob_rdata_i;
        w_tmo:   r_rdata <= TMO_RDATA[DATA_W-1:0];
        default: r_rdata <= r_rdata;
      endcase
    end
  end

  assign bus.cmd_ready_o = ~w_full;
  assign bus.iob_valid_o = r_iob_valid;
  assign bus.iob_addr_o  = r_addr;
  assign bus.iob_wdata_o = r_wdata;
  assign bus.iob_wstrb_o = r_wstrb;
  assign bus.rsp_valid_o = (r_state == ST_RSP);
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.busy_o      = (r_state != ST_IDLE)
                         | (w_count != '0);
endmodule

// File: tb/tb_iob_pbus_cmd_master.sv
// Bench for iob_pbus_cmd_master: vector table plus
// hand sequences for full FIFO, held response, reset, timeout.
module tb_iob_pbus_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef IOB_PBUS_CMD_MASTER_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 16;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cke   = 1'b1;
  always #5 clk = ~clk;

  iob_pbus_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  iob_pbus_cmd_master #(
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .FIFO_DEPTH_LOG2 (2),
    .TIMEOUT_W       (TW)
  ) dut (
    .clk_i    (clk),
    .arst_n_i (rst_n),
    .cke_i    (cke),
    .bus      (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          rdy_dly;
    int          rv_dly;
    logic [31:0] iob_rdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [5];
  int   n_run  = 0;
  int   n_fail = 0;
  int   pulses = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) begin
    if (bus.iob_valid_o && !prev_v) pulses++;
    prev_v = bus.iob_valid_o;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic        we,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  s);
    int k = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_addr_i  = a;
    bus.cmd_wdata_i = d;
    bus.cmd_wstrb_i = s;
    while (!bus.cmd_ready_o && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) chk("push_wait", 32'(k), 32'd0);
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic do_req(input logic        we,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [3:0]  ws,
                        input int          rdy,
                        input int          rv,
                        input logic [31:0] rd);
    int k = 0;
    while (!bus.iob_valid_o && k < 50) begin
      tick();
      k++;
    end
    chk("iob_valid_seen", 32'(bus.iob_valid_o), 32'd1);
    chk("iob_addr", bus.iob_addr_o, a);
    chk("iob_wdata", bus.iob_wdata_o, wd);
    chk("iob_wstrb", 32'(bus.iob_wstrb_o), 32'(ws));
    for (int i = 0; i < rdy; i++) begin
      tick();
      chk("hold_valid", 32'(bus.iob_valid_o), 32'd1);
      chk("hold_addr", bus.iob_addr_o, a);
      chk("hold_wstrb", 32'(bus.iob_wstrb_o), 32'(ws));
    end
    bus.iob_ready_i = 1'b1;
    if (rv == 0) begin
      bus.iob_rvalid_i = 1'b1;
      bus.iob_rdata_i  = rd;
    end
    tick();
    bus.iob_ready_i  = 1'b0;
    bus.iob_rvalid_i = 1'b0;
    chk("valid_drop", 32'(bus.iob_valid_o), 32'd0);
    if (!we && rv > 0) begin
      for (int i = 1; i < rv; i++) tick();
      bus.iob_rvalid_i = 1'b1;
      bus.iob_rdata_i  = rd;
      tick();
      bus.iob_rvalid_i = 1'b0;
    end
  endtask

  task automatic get_rsp(input logic [31:0] rd,
                         input logic        err,
                         input int          hold,
                         input logic        stray);
    int k = 0;
    while (!bus.rsp_valid_o && k < 50) begin
      tick();
      k++;
    end
    chk("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("rsp_rdata", bus.rsp_rdata_o, rd);
    chk("rsp_err", 32'(bus.rsp_err_o), 32'(err));
    for (int i = 0; i < hold; i++) begin
      if (stray && i == hold / 2) begin
        bus.iob_rvalid_i = 1'b1;
        bus.iob_rdata_i  = 32'hBAD0BAD0;
      end
      tick();
      bus.iob_rvalid_i = 1'b0;
      chk("held_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("held_rdata", bus.rsp_rdata_o, rd);
      chk("held_no_iob", 32'(bus.iob_valid_o), 32'd0);
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("rsp_taken", 32'(bus.rsp_valid_o), 32'd0);
    chk("err_clear", 32'(bus.rsp_err_o), 32'd0);
  endtask

  initial begin
    int p0;
    int k;
    vt[0] = '{1'b1, 32'h10, 32'hCAFEF00D, 4'hF,
              3, 0, 32'h0, 4'hF, 32'h0};
    vt[1] = '{1'b0, 32'h20, 32'h0000DEAD, 4'hF,
              0, 2, 32'h12345678, 4'h0, 32'h12345678};
    vt[2] = '{1'b0, 32'h24, 32'h0, 4'h3,
              1, 0, 32'hA5A55A5A, 4'h0, 32'hA5A55A5A};
    vt[3] = '{1'b1, 32'h30, 32'h11223344, 4'h5,
              0, 0, 32'h0000FFFF, 4'h5, 32'h0};
    vt[4] = '{1'b0, 32'h40, 32'h0, 4'h0,
              2, 1, 32'h0BADBEEF, 4'h0, 32'h0BADBEEF};

    bus.cmd_valid_i  = 1'b0;
    bus.cmd_we_i     = 1'b0;
    bus.cmd_addr_i   = '0;
    bus.cmd_wdata_i  = '0;
    bus.cmd_wstrb_i  = '0;
    bus.rsp_ready_i  = 1'b0;
    bus.iob_ready_i  = 1'b0;
    bus.iob_rvalid_i = 1'b0;
    bus.iob_rdata_i  = '0;

    repeat (3) tick();
    chk("rst_iob_valid", 32'(bus.iob_valid_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_rdata", bus.rsp_rdata_o, 32'd0);
    chk("rst_err", 32'(bus.rsp_err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      p0 = pulses;
      push(vt[i].we, vt[i].addr,
           vt[i].wdata, vt[i].wstrb);
      do_req(vt[i].we, vt[i].addr, vt[i].wdata,
             vt[i].exp_wstrb, vt[i].rdy_dly,
             vt[i].rv_dly, vt[i].iob_rdata);
      get_rsp(vt[i].exp_rdata, 1'b0, 0, 1'b0);
      chk("one_pulse", 32'(pulses - p0), 32'd1);
      chk("idle_busy", 32'(bus.busy_o), 32'd0);
    end

    for (int i = 0; i < 5; i++)
      push(1'b0, 32'h100 + 32'(4 * i),
           32'hDEAD0000 + 32'(i), 4'hF);
    chk("full_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("full_busy", 32'(bus.busy_o), 32'd1);
    chk("full_head", bus.iob_addr_o, 32'h100);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, 32'h100 + 32'(4 * i),
             32'hDEAD0000 + 32'(i), 4'h0,
             0, 0, 32'h5000 + 32'(i));
      get_rsp(32'h5000 + 32'(i), 1'b0, 0, 1'b0);
    end
    chk("drain_busy", 32'(bus.busy_o), 32'd0);

    push(1'b0, 32'h200, 32'h0, 4'h0);
    push(1'b0, 32'h204, 32'h0, 4'h0);
    do_req(1'b0, 32'h200, 32'h0, 4'h0,
           0, 0, 32'h600DCAFE);
    get_rsp(32'h600DCAFE, 1'b0, 10, 1'b1);
    do_req(1'b0, 32'h204, 32'h0, 4'h0,
           0, 0, 32'h0000C0DE);
    get_rsp(32'h0000C0DE, 1'b0, 0, 1'b0);

    cke = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = 32'h500;
    repeat (3) tick();
    bus.cmd_valid_i = 1'b0;
    cke = 1'b1;
    repeat (3) tick();
    chk("cke_no_push", 32'(bus.busy_o), 32'd0);

    push(1'b0, 32'h300, 32'h0, 4'h0);
    push(1'b1, 32'h304, 32'h77, 4'hF);
    k = 0;
    while (!bus.iob_valid_o && k < 50) begin
      tick();
      k++;
    end
    chk("pre_rst_valid", 32'(bus.iob_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.iob_valid_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_ready", 32'(bus.cmd_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_rsp", 32'(bus.rsp_valid_o), 32'd0);
    end
    chk("post_rst_pulse", 32'(pulses - p0), 32'd0);

`ifdef IOB_PBUS_CMD_MASTER_TIMEOUT_EN
    push(1'b0, 32'h400, 32'h0, 4'h0);
    k = 0;
    while (!bus.rsp_valid_o && k < 40) begin
      tick();
      k++;
    end
    chk("tmo_window", 32'(k >= 15 && k <= 20), 32'd1);
    chk("tmo_iob_valid", 32'(bus.iob_valid_o), 32'd0);
    get_rsp(32'hFFFFFFFF, 1'b1, 0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end
endmodule
